// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace producer.
//   - record type encodings carried on rec_type
//   - packed trace record {type, addr, data} (3+16+16 bits)
//   - statistics record indices emitted after HALT
//   - producer state encoding
package trace_pkg;

    localparam int REC_W = 3 + 16 + 16;

    localparam logic [2:0] REC_REG   = 3'd0;
    localparam logic [2:0] REC_LOAD  = 3'd1;
    localparam logic [2:0] REC_STORE = 3'd2;
    localparam logic [2:0] REC_HALT  = 3'd3;
    localparam logic [2:0] REC_STAT  = 3'd4;

    localparam logic [2:0] STAT_CYCLE = 3'd0;
    localparam logic [2:0] STAT_IREQ  = 3'd1;
    localparam logic [2:0] STAT_IHIT  = 3'd2;
    localparam logic [2:0] STAT_DREQ  = 3'd3;
    localparam logic [2:0] STAT_DHIT  = 3'd4;

    typedef struct packed {
        logic [2:0]  recType;
        logic [15:0] addr;
        logic [15:0] data;
    } traceRec_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_STATS = 2'd2,
        ST_DONE  = 2'd3
    } genState_e;

endpackage

// File: rtl/trace_fifo.sv
// Dual-write, single-read record FIFO.
//   clk, rst        clock, synchronous active-low reset
//   wrEn0/wrData0   first record of the cycle
//   wrEn1/wrData1   second record (only used together with port 0)
//   rdEn            pop the head record
//   head            oldest record, read from the flop array
//   empty, freeCnt  occupancy status (freeCnt counts free slots)
// Pointers carry one extra wrap bit; empty when they match, full when only
// the wrap bit differs (freeCnt == 0). Callers never write past freeCnt.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn0,
    input  traceRec_t                wrData0,
    input  logic                     wrEn1,
    input  traceRec_t                wrData1,
    input  logic                     rdEn,
    output traceRec_t                head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   freeCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    traceRec_t        mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr, used;
    logic [AW-1:0]    idx0, idx1;

    assign idx0    = wrPtr[AW-1:0];
    assign idx1    = idx0 + AW'(1);
    assign used    = wrPtr - rdPtr;
    assign freeCnt = PW'(DEPTH) - used;
    assign empty   = (wrPtr == rdPtr);
    // Head comes straight off the storage flops, so it holds steady while
    // the consumer stalls.
    assign head    = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(wrEn0) + PW'(wrEn1);
            if (rdEn) rdPtr <= rdPtr + PW'(1);
        end
    end

    // Storage needs no reset; contents are only observed behind valid pointers.
    always_ff @(posedge clk) begin
        if (wrEn0) mem[idx0] <= wrData0;
        if (wrEn1) mem[idx1] <= wrData1;
    end

endmodule

// File: rtl/retire_trace_gen.sv
// Commit-trace producer: turns retire events into REG/LOAD/STORE records,
// queues them, and after halt drains the queue and emits a HALT record.
//   clk, rst                 clock, synchronous active-low reset
//   reg_write..halt          per-cycle retire events from writeback/memory
//   icache_*/dcache_*        cache activity strobes
//   rec_valid/rec_ready      record handshake; rec_type/addr/data payload
//   trace_stall              fewer than 2 free slots, retire must hold
//   overflow, proto_err      sticky error flags
//   done                     final record accepted
//   cycle_cnt, inst_cnt      free-running counters (wrap modulo 2^CNT_W)
// Build option TRACE_CACHE_STATS_EN adds cache counters and five STAT
// records (cycles, icache req/hit, dcache req/hit) after HALT.
module retire_trace_gen
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [2:0]        write_reg,
    input  logic [15:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              halt,
    input  logic              icache_req,
    input  logic              icache_hit,
    input  logic              dcache_req,
    input  logic              dcache_hit,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_type,
    output logic [15:0]       rec_addr,
    output logic [15:0]       rec_data,
    output logic              trace_stall,
    output logic              overflow,
    output logic              proto_err,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);
    localparam int PW = $clog2(DEPTH) + 1;

    genState_e      state, stateNext;
    traceRec_t      regRec, loadRec, storeRec, wr0, wr1, head, recOut;
    logic           wrEn0, wrEn1, fifoEmpty, popFifo, inRun, keepStore, dropCycle;
    logic [PW-1:0]  freeCnt;
    logic [1:0]     need;
    logic [2:0]     statIdx;
    logic [15:0]    statVal;

    assign inRun    = (state == ST_RUN);
    assign regRec   = '{recType: REC_REG,   addr: {13'b0, write_reg}, data: write_data};
    assign loadRec  = '{recType: REC_LOAD,  addr: mem_addr, data: mem_rdata};
    assign storeRec = '{recType: REC_STORE, addr: mem_addr, data: mem_wdata};

    // A simultaneous load+store is a protocol error; the store is discarded,
    // which keeps the per-cycle demand at two records at most.
    assign keepStore = mem_write & ~mem_read;
    assign need      = 2'(reg_write) + 2'(mem_read) + 2'(keepStore);
    // All-or-nothing: a cycle that does not fit loses every record.
    assign dropCycle = inRun && (PW'(need) > freeCnt);

    // Pack the cycle's records onto the write ports in REG, LOAD, STORE order.
    always_comb begin
        wr0   = regRec;
        wr1   = loadRec;
        wrEn0 = 1'b0;
        wrEn1 = 1'b0;
        if (inRun && !dropCycle) begin
            if (reg_write) begin
                wrEn0 = 1'b1;
                if (mem_read) begin
                    wrEn1 = 1'b1;
                end else if (keepStore) begin
                    wr1   = storeRec;
                    wrEn1 = 1'b1;
                end
            end else if (mem_read) begin
                wr0   = loadRec;
                wrEn0 = 1'b1;
            end else if (keepStore) begin
                wr0   = storeRec;
                wrEn0 = 1'b1;
            end
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk     (clk),
        .rst     (rst),
        .wrEn0   (wrEn0),
        .wrData0 (wr0),
        .wrEn1   (wrEn1),
        .wrData1 (wr1),
        .rdEn    (popFifo),
        .head    (head),
        .empty   (fifoEmpty),
        .freeCnt (freeCnt)
    );

    assign trace_stall = (freeCnt < PW'(2));
    assign popFifo     = rec_ready && !fifoEmpty && (state == ST_RUN || state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign rec_type    = recOut.recType;
    assign rec_addr    = recOut.addr;
    assign rec_data    = recOut.data;

    // Output selection and next state.
    always_comb begin
        stateNext = state;
        rec_valid = 1'b0;
        recOut    = head;
        case (state)
            ST_RUN: begin
                rec_valid = !fifoEmpty;
                if (halt) stateNext = ST_DRAIN;
            end
            ST_DRAIN: begin
                rec_valid = 1'b1;
                if (fifoEmpty) begin
                    recOut = '{recType: REC_HALT, addr: 16'h0, data: inst_cnt[15:0]};
`ifdef TRACE_CACHE_STATS_EN
                    if (rec_ready) stateNext = ST_STATS;
`else
                    if (rec_ready) stateNext = ST_DONE;
`endif
                end
            end
`ifdef TRACE_CACHE_STATS_EN
            ST_STATS: begin
                rec_valid = 1'b1;
                recOut    = '{recType: REC_STAT, addr: {13'b0, statIdx}, data: statVal};
                if (rec_ready && statIdx == STAT_DHIT) stateNext = ST_DONE;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= stateNext;
            if (state != ST_DONE) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (inRun) begin
                if (reg_write | mem_write | halt) inst_cnt <= inst_cnt + CNT_W'(1);
                if (mem_read & mem_write)         proto_err <= 1'b1;
                if (dropCycle)                    overflow  <= 1'b1;
            end
        end
    end

`ifdef TRACE_CACHE_STATS_EN
    logic [CNT_W-1:0] icReqCnt, icHitCnt, dcReqCnt, dcHitCnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            icReqCnt <= '0;
            icHitCnt <= '0;
            dcReqCnt <= '0;
            dcHitCnt <= '0;
            statIdx  <= STAT_CYCLE;
        end else begin
            if (inRun) begin
                if (icache_req) icReqCnt <= icReqCnt + CNT_W'(1);
                if (icache_hit) icHitCnt <= icHitCnt + CNT_W'(1);
                if (dcache_req) dcReqCnt <= dcReqCnt + CNT_W'(1);
                if (dcache_hit) dcHitCnt <= dcHitCnt + CNT_W'(1);
            end
            if (state == ST_STATS && rec_ready) statIdx <= statIdx + 3'd1;
        end
    end

    always_comb begin
        case (statIdx)
            STAT_CYCLE: statVal = cycle_cnt[15:0];
            STAT_IREQ:  statVal = icReqCnt[15:0];
            STAT_IHIT:  statVal = icHitCnt[15:0];
            STAT_DREQ:  statVal = dcReqCnt[15:0];
            default:    statVal = dcHitCnt[15:0];
        endcase
    end
`else
    // Without the statistics option the strobes have no consumer.
    logic unusedStrobes;
    assign unusedStrobes = ^{icache_req, icache_hit, dcache_req, dcache_hit};
    assign statIdx       = STAT_CYCLE;
    assign statVal       = 16'h0;
`endif

endmodule
